// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scan path:
// the BCD nybble width, the scan state encoding and the digit index width helper.
package display_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON,
    OFF
  } scan_state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot timer: counts 0..DWELL_CYCLES-1 and wraps, with a terminal-count flag
// and an equality compare against a caller-supplied phase value.
module scan_timer #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [CNT_W-1:0] phase,
  output logic [CNT_W-1:0] count,
  output logic             tc,
  output logic             phase_hit
);

  logic [CNT_W-1:0] count_q, count_d;

  assign count     = count_q;
  assign tc        = (count_q == CNT_W'(DWELL_CYCLES - 1));
  assign phase_hit = (count_q == phase);

  // Next count: synchronous clear wins, otherwise advance and wrap at terminal count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (run) begin
      count_d = tc ? '0 : count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/display_scan_controller.sv
// Timed scan scheduler for a multiplexed 7-segment display: per-digit dwell,
// dead-time blanking, PWM brightness and a double-buffered number load that
// only swaps at frame boundaries.
// Optional: define DISPLAY_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DIGITS = 4,
  parameter int unsigned DWELL_CYCLES     = 100000,
  parameter int unsigned DEAD_CYCLES      = 1000,
  parameter int unsigned BRIGHT_W         = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [BRIGHT_W-1:0]                 brightness,
  input  logic [NUMBER_OF_DIGITS*BCD_W-1:0]   number_in,
  input  logic                                load_valid,
  output logic                                load_ready,
  output logic [idx_width(NUMBER_OF_DIGITS)-1:0] digit_idx,
  output logic [BCD_W-1:0]                    nybble_out,
  output logic [NUMBER_OF_DIGITS-1:0]         io_sel,
  output logic                                seg_en,
  output logic                                frame_start
);

  localparam int unsigned DW   = NUMBER_OF_DIGITS * BCD_W;
  localparam int unsigned IW   = idx_width(NUMBER_OF_DIGITS);
  localparam int unsigned TW   = $clog2(DWELL_CYCLES);
  localparam int unsigned STEP = (DWELL_CYCLES - DEAD_CYCLES) / (2 ** BRIGHT_W);

  scan_state_e         state_q, state_d;
  logic [IW-1:0]       digit_q, digit_d;
  logic [TW-1:0]       on_q, on_d;
  logic [DW-1:0]       disp_q, disp_d, pend_q, pend_d;
  logic                ready_q, ready_d;
  logic [BCD_W-1:0]    nybble_q, nybble_d;
  logic [NUMBER_OF_DIGITS-1:0] sel_q, sel_d;
  logic                seg_q, seg_d, fs_q, fs_d;

  logic [TW-1:0]       t, phase;
  logic                tc, phase_hit, dead_entry, first_dead, blank;

  // DEAD ends at DEAD_CYCLES-1; ON ends on_q cycles later.
  assign phase = (state_q == DEAD) ? TW'(DEAD_CYCLES - 1) : TW'(DEAD_CYCLES - 1) + on_q;

  scan_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (TW)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!enable || (state_q == IDLE)),
    .run       (1'b1),
    .phase     (phase),
    .count     (t),
    .tc        (tc),
    .phase_hit (phase_hit)
  );

  // Scan sequencing: slot phases, digit advance and forced idle on disable.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = DEAD;
          digit_d = '0;
        end
      end
      DEAD: if (phase_hit) state_d = (on_q != '0) ? ON : OFF;
      ON:   if (phase_hit) state_d = OFF;
      OFF: begin
        if (tc) begin
          state_d = DEAD;
          digit_d = (digit_q == IW'(NUMBER_OF_DIGITS - 1)) ? '0 : digit_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      digit_d = '0;
    end
  end

  assign dead_entry = (state_d == DEAD) && (state_q != DEAD);
  assign first_dead = (state_q == DEAD) && (t == '0);

  // Buffers, handshake, latched duty and registered output values.
  always_comb begin
    on_d     = dead_entry ? TW'(brightness * STEP) : on_q;
    disp_d   = disp_q;
    pend_d   = pend_q;
    ready_d  = ready_q;
    // The swap happens in the first DEAD cycle of digit 0; a load accepted in that
    // same cycle sees an empty pending buffer and waits for the next frame.
    if (first_dead && (digit_q == '0) && !ready_q) begin
      disp_d  = pend_q;
      ready_d = 1'b1;
    end
    if (load_valid && ready_q) begin
      pend_d  = number_in;
      ready_d = 1'b0;
    end
    nybble_d = first_dead ? disp_d[digit_q*BCD_W +: BCD_W] : nybble_q;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    blank = (digit_d != '0) && ((disp_d >> (digit_d * BCD_W)) == '0);
`else
    blank = 1'b0;
`endif
    seg_d = (state_d == ON) && !blank;
    sel_d = (state_d == ON) ? ~(NUMBER_OF_DIGITS'(1) << digit_d) : '1;
    fs_d  = dead_entry && (digit_d == '0);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digit_q  <= '0;
      on_q     <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      ready_q  <= 1'b1;
      nybble_q <= '0;
      sel_q    <= '1;
      seg_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      on_q     <= on_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      ready_q  <= ready_d;
      nybble_q <= nybble_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end

  assign load_ready  = ready_q;
  assign digit_idx   = digit_q;
  assign nybble_out  = nybble_q;
  assign io_sel      = sel_q;
  assign seg_en      = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Bench for display_scan_controller: a slot-position model predicts every output
// each cycle; directed phases pin the model with literal values, then random traffic.
module tb_display_scan_controller;

  localparam int N     = 4;
  localparam int DWELL = 16;
  localparam int DEAD  = 2;
  localparam int BW    = 2;
  localparam int STEP  = (DWELL - DEAD) / (1 << BW);

`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
  localparam int LIT42 = 18;
  localparam int LIT00 = 9;
`else
  localparam int LIT42 = 36;
  localparam int LIT00 = 36;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [BW-1:0] brightness = '0;
  logic [15:0]   number_in = '0;
  logic          load_valid = 1'b0;
  logic          load_ready, seg_en, frame_start;
  logic [1:0]    digit_idx;
  logic [3:0]    nybble_out, io_sel;

  always #5 clk = ~clk;

  display_scan_controller #(
    .NUMBER_OF_DIGITS (N),
    .DWELL_CYCLES     (DWELL),
    .DEAD_CYCLES      (DEAD),
    .BRIGHT_W         (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .brightness  (brightness),
    .number_in   (number_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digit_idx   (digit_idx),
    .nybble_out  (nybble_out),
    .io_sel      (io_sel),
    .seg_en      (seg_en),
    .frame_start (frame_start)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: slot position, digit, latched on-time, buffers.
  bit          m_run = 0, m_full = 0, xfer;
  int          m_pos = 0, m_dig = 0, m_on = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  logic [3:0]  m_nyb = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_pos = 0; m_dig = 0; m_on = 0;
      m_disp = '0; m_pend = '0; m_full = 0; m_nyb = '0;
    end else begin
      xfer = load_valid && !m_full;
      if (m_run && m_pos == 0) begin
        if (m_dig == 0 && m_full) begin
          m_disp = m_pend;
          m_full = 0;
        end
        m_nyb = m_disp[m_dig*4 +: 4];
      end
      if (xfer) begin
        m_pend = number_in;
        m_full = 1;
      end
      if (!enable) begin
        m_run = 0; m_pos = 0; m_dig = 0;
      end else if (!m_run) begin
        m_run = 1; m_pos = 0; m_dig = 0; m_on = int'(brightness) * STEP;
      end else if (m_pos == DWELL - 1) begin
        m_pos = 0; m_dig = (m_dig + 1) % N; m_on = int'(brightness) * STEP;
      end else begin
        m_pos++;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    bit       win, blank;
    logic [3:0] esel;
    @(negedge clk);
    if (chk_on) begin
      win   = m_run && m_pos >= DEAD && m_pos < DEAD + m_on;
      blank = 0;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
      blank = (m_dig != 0) && ((m_disp >> (4 * m_dig)) == 16'h0);
`endif
      esel = 4'hF;
      if (win) esel[m_dig] = 1'b0;
      check("io_sel", io_sel, esel);
      check("seg_en", seg_en, win && !blank);
      check("frame_start", frame_start, m_run && m_pos == 0 && m_dig == 0);
      check("digit_idx", digit_idx, m_dig);
      check("nybble_out", nybble_out, m_nyb);
      check("load_ready", load_ready, !m_full);
    end
  end

  task automatic wait_frame(input int max);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < max);
    check("wait_frame_timeout", frame_start, 1);
  endtask

  task automatic count_seg(input int cycles, output int on_cnt, output int sel_cnt);
    on_cnt = 0;
    sel_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (seg_en === 1'b1) on_cnt++;
      if (io_sel !== 4'hF) sel_cnt++;
    end
  endtask

  initial begin
    int         on_cnt, sel_cnt, n;
    logic [3:0] sel_seen [4];

    #22 rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_io_sel", io_sel, 4'hF);
    check("rst_seg_en", seg_en, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_nybble", nybble_out, 0);

    // Scan at full brightness: 2 DEAD, 9 ON, 5 OFF per slot.
    enable = 1'b1;
    brightness = 2'd3;
    @(negedge clk);
    check("t1_first_frame_start", frame_start, 1);
    on_cnt = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k < 16 && seg_en === 1'b1) on_cnt++;
      if (k % 16 == 2) sel_seen[k/16] = io_sel;
    end
    check("t1_on_cycles", on_cnt, 9);
    check("t1_sel_d0", sel_seen[0], 4'b1110);
    check("t1_sel_d1", sel_seen[1], 4'b1101);
    check("t1_sel_d2", sel_seen[2], 4'b1011);
    check("t1_sel_d3", sel_seen[3], 4'b0111);
    check("t1_frame_period", frame_start, 1);

    // Mid-frame load.
    repeat (5) @(negedge clk);
    load_valid = 1'b1;
    number_in  = 16'h1234;
    @(negedge clk);
    load_valid = 1'b0;
    check("t2_ready_low", load_ready, 0);
    wait_frame(80);
    @(negedge clk);
    check("t2_ready_back", load_ready, 1);
    check("t2_nyb_d0", nybble_out, 4'h4);
    repeat (16) @(negedge clk);
    check("t2_nyb_d1", nybble_out, 4'h3);
    repeat (16) @(negedge clk);
    check("t2_nyb_d2", nybble_out, 4'h2);
    repeat (16) @(negedge clk);
    check("t2_nyb_d3", nybble_out, 4'h1);

    // Dark, then brightness 1 mid-slot.
    brightness = 2'd0;
    wait_frame(80);
    count_seg(64, on_cnt, sel_cnt);
    check("t3_dark_seg", on_cnt, 0);
    check("t3_dark_sel", sel_cnt, 0);
    repeat (5) @(negedge clk);
    brightness = 2'd1;
    repeat (11) @(negedge clk);
    count_seg(16, on_cnt, sel_cnt);
    check("t3_dim_on", on_cnt, 3);

    // Disable during ON of digit 2, then re-enable.
    brightness = 2'd3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(digit_idx === 2'd2 && seg_en === 1'b1) && n < 200);
    check("t4_reach_d2_on", seg_en, 1);
    enable = 1'b0;
    @(negedge clk);
    check("t4_idle_sel", io_sel, 4'hF);
    check("t4_idle_seg", seg_en, 0);
    check("t4_idle_idx", digit_idx, 0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    check("t4_restart_fs", frame_start, 1);
    check("t4_restart_idx", digit_idx, 0);

    // Load on the frame_start cycle; a second load while busy is dropped.
    load_valid = 1'b1;
    number_in  = 16'h0042;
    @(negedge clk);
    check("t5_ready_low", load_ready, 0);
    check("t5_old_value", nybble_out, 4'h4);
    number_in = 16'h9999;
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    wait_frame(80);
    @(negedge clk);
    check("t5_new_value", nybble_out, 4'h2);
    check("t5_ready_back", load_ready, 1);

    // Leading-zero behaviour.
    count_seg(64, on_cnt, sel_cnt);
    check("t6_0042_on", on_cnt, LIT42);
    check("t6_0042_sel", sel_cnt, 36);
    load_valid = 1'b1;
    number_in  = 16'h0000;
    @(negedge clk);
    load_valid = 1'b0;
    wait_frame(80);
    @(negedge clk);
    count_seg(64, on_cnt, sel_cnt);
    check("t6_0000_on", on_cnt, LIT00);

    // Asynchronous reset mid-operation.
    load_valid = 1'b1;
    number_in  = 16'h5678;
    repeat (7) @(negedge clk);
    load_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_sel", io_sel, 4'hF);
    check("arst_seg", seg_en, 0);
    check("arst_ready", load_ready, 1);
    check("arst_nybble", nybble_out, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      enable = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) brightness = BW'($urandom);
      load_valid = ($urandom_range(0, 3) == 0);
      number_in  = 16'($urandom) >> (4 * $urandom_range(0, 4));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
Sequences the multiplexed 7-segment display path, replacing a free-running digit counter with a timed scan scheduler.
- Scan: per-digit dwell timer, dead-time blanking between digits, and PWM brightness within each digit slot.
- Data: double-buffered number load; new values are applied only at frame boundaries, so digits never tear.
- Outputs: the selected nybble, digit select and segment enable, which feed the BCD decoder and the io_sel/io_seg pins.

Parameters:
- NUMBER_OF_DIGITS, 4, digits scanned (2..8).
- DWELL_CYCLES, 100000, clk cycles per digit slot (greater than DEAD_CYCLES + 2**BRIGHT_W).
- DEAD_CYCLES, 1000, blanked cycles at the start of each slot (at least 1).
- BRIGHT_W, 4, brightness code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable.
- brightness  in  BRIGHT_W  duty code; 0 means dark.
- number_in  in  NUMBER_OF_DIGITS*4  packed BCD, digit 0 in [3:0].
- load_valid  in  1  number_in is valid.
- load_ready  out  1  pending buffer is free.
- digit_idx  out  clog2(NUMBER_OF_DIGITS)  digit being scanned.
- nybble_out  out  4  BCD value of the current digit, to the decoder.
- io_sel  out  NUMBER_OF_DIGITS  one-hot active-low digit select.
- seg_en  out  1  segment drive enable.
- frame_start  out  1  one-cycle pulse at the start of digit 0.

Behaviour:
- All outputs are registered.
- Reset values: io_sel all 1, seg_en 0, digit_idx 0, nybble_out 0, frame_start 0, load_ready 1. The display buffer and the pending buffer reset to 0.
- State machine: IDLE, DEAD, ON, OFF. A slot timer t runs 0..DWELL_CYCLES-1.
- Duty constants:
  - STEP = (DWELL_CYCLES-DEAD_CYCLES) / 2**BRIGHT_W, integer division.
  - on_cycles = brightness*STEP, with brightness sampled at DEAD entry.
- IDLE → DEAD when enable=1. Entering DEAD from IDLE is a frame boundary (digit 0).
- DEAD: io_sel all 1, seg_en 0, lasting DEAD_CYCLES cycles.
  - Then → ON if on_cycles>0, else → OFF.
- ON: io_sel[digit_idx]=0, others 1, seg_en 1, lasting on_cycles cycles, then → OFF.
- OFF: io_sel all 1, seg_en 0, until t=DWELL_CYCLES-1.
  - Then digit_idx increments, wrapping from NUMBER_OF_DIGITS-1 to 0, and the state → DEAD.
- The wrap to 0 is a frame boundary. frame_start is high for the first DEAD cycle of digit 0.
- nybble_out = display_buf[digit_idx*4 +: 4]. It updates on the DEAD-entry cycle, so it is stable before the select asserts.
- Load handshake:
  - A transfer occurs when load_valid & load_ready.
  - On transfer, number_in is captured into the pending buffer and load_ready falls next cycle.
  - At the next frame boundary, pending is copied to display_buf and load_ready rises the following cycle.
- Simultaneous transfer and frame boundary on the same cycle: the new value is captured into pending. It is not copied until the next boundary.
- enable falls mid-slot: → IDLE next cycle. io_sel all 1, seg_en 0, t=0, digit_idx=0. Loads are still accepted, and a pending value remains pending.
- brightness changes mid-slot: take effect at the next DEAD entry.
- rst_n asserted mid-operation: outputs return to reset values immediately. Both buffers clear.

Optional Feature:
- Macro: DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined: leading zeros are blanked. While in ON, seg_en is forced 0 for any digit whose value is 0 when every higher digit is also 0. Digit 0 is never blanked. The timing of io_sel is unchanged.
- Undefined: all digits are driven normally.

Decomposition:
- Shared package display_pkg holds:
  - BCD_W = 4;
  - the scan state enum {IDLE, DEAD, ON, OFF};
  - the clog2-based width function used for digit_idx.
- Sub-module scan_timer: slot counter with a terminal-count pulse and a phase-compare output. It is parameterized by DWELL_CYCLES and reusable by other timed blocks.
- Buffers and the state machine live in the top module.

Test Plan:
All scenarios use NUMBER_OF_DIGITS=4, DWELL_CYCLES=16, DEAD_CYCLES=2, BRIGHT_W=2, giving STEP=3.
1. Reset → io_sel=4'b1111, seg_en=0, load_ready=1. Then enable=1, brightness=3 → each slot is 2 DEAD cycles, 9 ON cycles and 5 OFF cycles. io_sel goes 1110, 1101, 1011, 0111, and frame_start pulses every 64 cycles.
2. Load 16'h1234 mid-frame → load_ready drops next cycle. nybble_out shows 0s until the next frame_start, then 4,3,2,1 for digits 0..3. load_ready returns to 1 one cycle after frame_start.
3. brightness=0 → seg_en is never 1 and io_sel stays 1111. Changing it to 1 mid-slot → 3-cycle ON windows start from the next slot.
4. enable is dropped during ON of digit 2 → next cycle io_sel=1111, seg_en=0, digit_idx=0. Re-enable → frame_start pulses and digit 0 scans first.
5. load_valid asserted on the frame_start cycle with 16'h0042 → displayed only after the following frame_start. A second load_valid while load_ready=0 is ignored.
6. With DISPLAY_LEADING_ZERO_BLANK_EN and value 16'h0042 → seg_en=1 only in the ON windows of digits 0 and 1. Value 16'h0000 → only digit 0 is lit.
